// File: rtl/shot_scheduler.sv
// rtl/shot_scheduler.sv - two-player artillery turn controller owning the shared projectile datapath
module shot_scheduler #(
   parameter int TIMEOUT_TICKS = 1023,
   parameter int WIN_SCORE     = 5,
   parameter int SCORE_W       = 4
) (
   input  logic               clock_50m,
   input  logic               rst,
   input  logic               move_tick,
   input  logic [1:0]         fire_req,
   input  logic [7:0]         angle_p0,
   input  logic [7:0]         angle_p1,
   input  logic [7:0]         power_p0,
   input  logic [7:0]         power_p1,
   input  logic [17:0]        pos_x_p0,
   input  logic [17:0]        pos_x_p1,
   input  logic [17:0]        pos_y_p0,
   input  logic [17:0]        pos_y_p1,
   input  logic               shot_done,
   input  logic               shot_hit,
   output logic               cannon_turn,
   output logic [7:0]         angle,
   output logic [7:0]         power,
   output logic [17:0]        start_pos_x,
   output logic [17:0]        start_pos_y,
   output logic               direction,
   output logic               cur_player,
   output logic [SCORE_W-1:0] score_p0,
   output logic [SCORE_W-1:0] score_p1,
   output logic               busy,
   output logic               game_over,
   output logic               winner
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_FLY,
      S_RESOLVE,
      S_OVER
   } state_t;

   localparam logic [9:0]         TMO_LAST = 10'(TIMEOUT_TICKS - 1);
   localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t             state;
   state_t             state_nxt;
   logic [9:0]         tmo_cnt;
   logic               tick_seen;
   logic               hit_q;
   logic               req_own;
   logic               final_tick;
   logic [SCORE_W-1:0] shooter_score;
   logic [SCORE_W-1:0] score_inc;
   logic               win_now;

   // Only the active player's request bit counts; the other player waits its turn.
   assign req_own       = fire_req[cur_player];
   assign final_tick    = move_tick && (tmo_cnt == TMO_LAST);
   assign shooter_score = cur_player ? score_p1 : score_p0;
   assign score_inc     = (shooter_score == SCORE_MAX) ? shooter_score : shooter_score + 1'b1;
   assign win_now       = hit_q && (score_inc >= WIN_S);

   always_ff @(posedge clock_50m) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (req_own) state_nxt = S_LOAD;
         S_LOAD:    state_nxt = S_ARM;
         S_ARM:     if (move_tick || tick_seen) state_nxt = S_FLY;
         S_FLY:     if (shot_done || final_tick) state_nxt = S_RESOLVE;
         S_RESOLVE: state_nxt = win_now ? S_OVER : S_IDLE;
         S_OVER:    state_nxt = S_OVER;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cannon_turn = 1'b0;
      busy        = 1'b0;
      case (state)
         S_IDLE, S_OVER: busy = 1'b0;
         S_ARM: begin
            cannon_turn = 1'b1;
            busy        = 1'b1;
         end
         default: busy = 1'b1;
      endcase
   end

   always_ff @(posedge clock_50m) begin
      if (rst) begin
         angle       <= '0;
         power       <= '0;
         start_pos_x <= '0;
         start_pos_y <= '0;
         direction   <= 1'b0;
      end else if (state == S_LOAD) begin
         angle       <= cur_player ? angle_p1 : angle_p0;
         power       <= cur_player ? power_p1 : power_p0;
         start_pos_x <= cur_player ? pos_x_p1 : pos_x_p0;
         start_pos_y <= cur_player ? pos_y_p1 : pos_y_p0;
         direction   <= ~cur_player;
      end
   end

   // tick_seen guarantees the slow clock has sampled the strobe before flight starts.
   always_ff @(posedge clock_50m) begin
      if (rst) begin
         tick_seen <= 1'b0;
         tmo_cnt   <= '0;
         hit_q     <= 1'b0;
      end else begin
         case (state)
            S_LOAD: tick_seen <= 1'b0;
            S_ARM: begin
               if (move_tick) begin
                  tick_seen <= 1'b1;
                  tmo_cnt   <= '0;
               end
            end
            S_FLY: begin
               if (move_tick) tmo_cnt <= tmo_cnt + 1'b1;
               hit_q <= shot_done && shot_hit;
            end
            default: ;
         endcase
      end
   end

   // A timeout leaves FLY with shot_done low, so hit_q records a miss.
   always_ff @(posedge clock_50m) begin
      if (rst) begin
         score_p0   <= '0;
         score_p1   <= '0;
         cur_player <= 1'b0;
         game_over  <= 1'b0;
         winner     <= 1'b0;
      end else if (state == S_RESOLVE) begin
         if (hit_q) begin
            if (cur_player) score_p1 <= score_inc;
            else            score_p0 <= score_inc;
         end
         if (win_now) begin
            game_over <= 1'b1;
            winner    <= cur_player;
         end else begin
            cur_player <= ~cur_player;
         end
      end
   end

endmodule

// File: tb/tb_shot_scheduler.sv
// tb/tb_shot_scheduler.sv - scoreboard bench for shot_scheduler
module tb_shot_scheduler;

   logic        clock_50m = 1'b0;
   logic        rst;
   logic        move_tick;
   logic [1:0]  fire_req;
   logic [7:0]  angle_p0, angle_p1, power_p0, power_p1;
   logic [17:0] pos_x_p0, pos_x_p1, pos_y_p0, pos_y_p1;
   logic        shot_done, shot_hit;
   logic        cannon_turn;
   logic [7:0]  angle, power;
   logic [17:0] start_pos_x, start_pos_y;
   logic        direction, cur_player;
   logic [3:0]  score_p0, score_p1;
   logic        busy, game_over, winner;

   always #5 clock_50m = ~clock_50m;

   shot_scheduler #(.TIMEOUT_TICKS(1023), .WIN_SCORE(5), .SCORE_W(4)) dut (
      .clock_50m(clock_50m), .rst(rst), .move_tick(move_tick), .fire_req(fire_req),
      .angle_p0(angle_p0), .angle_p1(angle_p1), .power_p0(power_p0), .power_p1(power_p1),
      .pos_x_p0(pos_x_p0), .pos_x_p1(pos_x_p1), .pos_y_p0(pos_y_p0), .pos_y_p1(pos_y_p1),
      .shot_done(shot_done), .shot_hit(shot_hit), .cannon_turn(cannon_turn),
      .angle(angle), .power(power), .start_pos_x(start_pos_x), .start_pos_y(start_pos_y),
      .direction(direction), .cur_player(cur_player), .score_p0(score_p0),
      .score_p1(score_p1), .busy(busy), .game_over(game_over), .winner(winner)
   );

   typedef struct {
      logic [7:0]  ang;
      logic [7:0]  pow;
      logic [17:0] x;
      logic [17:0] y;
      logic        dir;
      logic        player;
   } launch_t;

   typedef struct {
      logic       player;
      logic [3:0] s0;
      logic [3:0] s1;
      logic       go;
      logic       win;
   } resolve_t;

   launch_t  lq[$];
   resolve_t rq[$];
   launch_t  mon_l;
   resolve_t mon_r;

   int checks = 0;
   int errors = 0;

   logic       m_player, m_go, m_win;
   logic [3:0] m_s0, m_s1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: a launch is cannon_turn rising, a turn end is busy falling.
   logic prev_ct = 1'b0;
   logic prev_busy = 1'b0;
   always @(negedge clock_50m) begin
      if (cannon_turn === 1'b1 && prev_ct == 1'b0) begin
         if (lq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_launch actual=1 required=0");
         end else begin
            mon_l = lq.pop_front();
            chk("launch_angle", angle, mon_l.ang);
            chk("launch_power", power, mon_l.pow);
            chk("launch_x", start_pos_x, mon_l.x);
            chk("launch_y", start_pos_y, mon_l.y);
            chk("launch_dir", direction, mon_l.dir);
            chk("launch_player", cur_player, mon_l.player);
         end
      end
      if (busy === 1'b0 && prev_busy == 1'b1) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_turn_end actual=1 required=0");
         end else begin
            mon_r = rq.pop_front();
            chk("end_player", cur_player, mon_r.player);
            chk("end_score_p0", score_p0, mon_r.s0);
            chk("end_score_p1", score_p1, mon_r.s1);
            chk("end_game_over", game_over, mon_r.go);
            chk("end_winner", winner, mon_r.win);
         end
      end
      prev_ct   = (cannon_turn === 1'b1);
      prev_busy = (busy === 1'b1);
   end

   task automatic cy();
      @(posedge clock_50m);
      #1;
   endtask

   task automatic model_reset();
      m_player = 1'b0; m_go = 1'b0; m_win = 1'b0; m_s0 = 4'd0; m_s1 = 4'd0;
   endtask

   task automatic model_resolve(input logic hit);
      if (hit) begin
         if (m_player == 1'b0) begin
            if (m_s0 != 4'hF) m_s0 = m_s0 + 4'd1;
            if (m_s0 >= 4'd5) begin m_go = 1'b1; m_win = 1'b0; end
         end else begin
            if (m_s1 != 4'hF) m_s1 = m_s1 + 4'd1;
            if (m_s1 >= 4'd5) begin m_go = 1'b1; m_win = 1'b1; end
         end
      end
      if (!m_go) m_player = ~m_player;
      rq.push_back('{player: m_player, s0: m_s0, s1: m_s1, go: m_go, win: m_win});
   endtask

   task automatic fire(input logic p, input logic [7:0] a, input logic [7:0] pw,
                       input logic [17:0] x, input logic [17:0] y);
      if (p) begin
         angle_p1 = a; power_p1 = pw; pos_x_p1 = x; pos_y_p1 = y;
      end else begin
         angle_p0 = a; power_p0 = pw; pos_x_p0 = x; pos_y_p0 = y;
      end
      lq.push_back('{ang: a, pow: pw, x: x, y: y, dir: ~p, player: p});
      chk("turn_owner", cur_player, p);
      fire_req = p ? 2'b10 : 2'b01;
      cy();
      chk("launch_lat1_turn", cannon_turn, 1'b0);
      chk("launch_lat1_busy", busy, 1'b1);
      cy();
      chk("launch_lat2_turn", cannon_turn, 1'b1);
      fire_req = 2'b00;
      // Disturb the inputs; latched values must not follow.
      angle_p0 = ~angle_p0; power_p0 = ~power_p0; pos_x_p0 = ~pos_x_p0; pos_y_p0 = ~pos_y_p0;
      angle_p1 = ~angle_p1; power_p1 = ~power_p1; pos_x_p1 = ~pos_x_p1; pos_y_p1 = ~pos_y_p1;
   endtask

   task automatic release_arm(input int hold);
      repeat (hold) begin
         cy();
         chk("arm_hold", cannon_turn, 1'b1);
      end
      move_tick = 1'b1;
      cy();
      move_tick = 1'b0;
      chk("arm_drop", cannon_turn, 1'b0);
      chk("fly_busy", busy, 1'b1);
   endtask

   task automatic end_shot(input logic hit);
      logic old;
      old = cur_player;
      model_resolve(hit);
      shot_done = 1'b1; shot_hit = hit;
      cy();
      shot_done = 1'b0; shot_hit = 1'b0;
      chk("resolve_lat1_player", cur_player, old);
      cy();
      chk("resolve_lat2_player", cur_player, m_player);
      chk("resolve_idle", busy, 1'b0);
   endtask

   task automatic run_timeout(input logic hit_on_last);
      logic old;
      old = cur_player;
      repeat (1022) begin
         move_tick = 1'b1;
         cy();
      end
      move_tick = 1'b0;
      chk("tmo_still_flying", busy, 1'b1);
      chk("tmo_player_kept", cur_player, old);
      model_resolve(hit_on_last);
      move_tick = 1'b1;
      shot_done = hit_on_last; shot_hit = hit_on_last;
      cy();
      move_tick = 1'b0; shot_done = 1'b0; shot_hit = 1'b0;
      cy();
      chk("tmo_player", cur_player, m_player);
      chk("tmo_idle", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; move_tick = 1'b0; fire_req = 2'b00; shot_done = 1'b0; shot_hit = 1'b0;
      angle_p0 = 8'h00; angle_p1 = 8'h00; power_p0 = 8'h00; power_p1 = 8'h00;
      pos_x_p0 = '0; pos_x_p1 = '0; pos_y_p0 = '0; pos_y_p1 = '0;
      model_reset();
      repeat (3) cy();
      rst = 1'b0;
      chk("rst_cannon_turn", cannon_turn, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cur_player", cur_player, 1'b0);
      chk("rst_scores", {score_p0, score_p1}, 8'h00);
      chk("rst_game_over", game_over, 1'b0);
      chk("rst_angle_power", {angle, power}, 16'h0000);

      // Wrong player's request is ignored.
      fire_req = 2'b10;
      repeat (100) begin
         cy();
         chk("wrong_player_turn", cannon_turn, 1'b0);
         chk("wrong_player_busy", busy, 1'b0);
      end
      fire_req = 2'b00;

      fire(1'b0, 8'h2D, 8'h40, 18'd100, 18'd200);
      release_arm(3);
      end_shot(1'b1);
      fire(1'b1, 8'h30, 8'h22, 18'd3000, 18'd150);
      release_arm(0);
      end_shot(1'b0);

      fire(1'b0, 8'h11, 8'h55, 18'd120, 18'd210);
      release_arm(1);
      run_timeout(1'b0);
      fire(1'b1, 8'h44, 8'h66, 18'h3FFFF, 18'h20000);
      release_arm(2);
      run_timeout(1'b1);

      for (int i = 0; i < 4; i++) begin
         fire(1'b0, 8'h50 + 8'(i), 8'h70 + 8'(i), 18'd500 + 18'(i), 18'd90);
         release_arm(i);
         end_shot(1'b1);
         if (i < 3) begin
            fire(1'b1, 8'hA0 + 8'(i), 8'h10, 18'd2500, 18'd95);
            release_arm(1);
            end_shot(1'b0);
         end
      end
      chk("over_game_over", game_over, 1'b1);
      chk("over_winner", winner, 1'b0);
      chk("over_score_p0", score_p0, 4'd5);

      // Terminal state ignores everything.
      fire_req = 2'b11;
      repeat (20) begin
         shot_done = 1'b1; shot_hit = 1'b1; move_tick = 1'b1;
         cy();
         chk("over_no_turn", cannon_turn, 1'b0);
         chk("over_not_busy", busy, 1'b0);
      end
      fire_req = 2'b00; shot_done = 1'b0; shot_hit = 1'b0; move_tick = 1'b0;
      chk("over_score_kept", {score_p0, score_p1}, {4'd5, 4'd1});

      rst = 1'b1;
      model_reset();
      cy();
      rst = 1'b0;
      chk("rst2_game_over", game_over, 1'b0);
      chk("rst2_scores", {score_p0, score_p1}, 8'h00);
      chk("rst2_launch", {angle, power, direction}, 17'h0);
      chk("rst2_pos", {start_pos_x, start_pos_y}, 36'h0);

      fire(1'b0, 8'h21, 8'h31, 18'd77, 18'd88);
      release_arm(0);
      end_shot(1'b1);
      fire(1'b1, 8'h22, 8'h32, 18'd99, 18'd66);
      release_arm(1);
      repeat (5) begin move_tick = 1'b1; cy(); end
      move_tick = 1'b0;
      model_reset();
      rq.push_back('{player: 1'b0, s0: 4'd0, s1: 4'd0, go: 1'b0, win: 1'b0});
      rst = 1'b1;
      cy();
      rst = 1'b0;
      chk("midfly_rst_busy", busy, 1'b0);
      chk("midfly_rst_turn", cannon_turn, 1'b0);
      chk("midfly_rst_player", cur_player, 1'b0);
      shot_done = 1'b1; shot_hit = 1'b1;
      cy();
      shot_done = 1'b0; shot_hit = 1'b0;
      repeat (5) cy();
      chk("late_done_scores", {score_p0, score_p1}, 8'h00);
      chk("late_done_busy", busy, 1'b0);

      cy();
      chk("launch_queue_empty", lq.size(), 0);
      chk("resolve_queue_empty", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shot_scheduler.md
Name: shot_scheduler

Overview:
- Turn controller for the two-player artillery game; owns the single shared projectile datapath.
- Arbitrates fire requests from player 0 and player 1 in strict alternation.
- Latches the active player's launch parameters, holds the projectile's turn strobe until the slow motion clock has sampled it, then waits for the flight result or a timeout.
- Keeps per-player scores and flags game over.

Parameters:
TIMEOUT_TICKS, 1023, max motion ticks allowed in flight before forced abort (10-bit counter)
WIN_SCORE, 5, score at which game_over asserts
SCORE_W, 4, score register width

Ports:
clock_50m  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
move_tick  in  1  1-cycle enable, coincident with each rising edge of the slow motion clock
fire_req  in  2  per-player fire request level; bit0 = player 0
angle_p0 / angle_p1  in  8  launch angle per player
power_p0 / power_p1  in  8  launch power per player
pos_x_p0 / pos_x_p1  in  18  tank x position
pos_y_p0 / pos_y_p1  in  18  tank y position
shot_done  in  1  1-cycle pulse from projectile: flight ended
shot_hit  in  1  qualifies shot_done: 1 = exploded on a target, 0 = left board
cannon_turn  out  1  launch strobe to projectile
angle / power  out  8  latched launch parameters
start_pos_x / start_pos_y  out  18  latched launch position
direction  out  1  0 = left, 1 = right; player 0 fires right, player 1 fires left
cur_player  out  1  whose turn it is
score_p0 / score_p1  out  SCORE_W  scores
busy  out  1  high in any state except IDLE and OVER
game_over  out  1  latched end of game
winner  out  1  valid when game_over is high

Behaviour:
- Reset values: all outputs 0, state IDLE, cur_player 0, timeout counter 0, tick_seen 0.
- Reset mid-flight aborts immediately with no score change. cannon_turn drops on the same edge.
- States: IDLE, LOAD, ARM, FLY, RESOLVE, OVER.
- IDLE:
  - Only fire_req[cur_player] is honoured; the other bit is ignored.
  - Request seen high -> LOAD next cycle.
- LOAD (1 cycle):
  - Latch angle, power, start_pos_x, start_pos_y and direction from cur_player's inputs.
  - Latched values stay stable until the next LOAD; input changes after LOAD have no effect.
  - -> ARM.
- ARM:
  - cannon_turn = 1.
  - Stay until move_tick has been seen once, so the slow clock samples the strobe.
  - On the first move_tick: set tick_seen, clear the timeout counter, -> FLY.
  - cannon_turn drops on entry to FLY; it is high for the whole ARM stay (at least 1 cycle).
- FLY:
  - Each move_tick increments the timeout counter.
  - shot_done -> RESOLVE.
  - Counter reaching TIMEOUT_TICKS -> RESOLVE, treated as a miss.
  - shot_done and the final tick on the same cycle: shot_done wins and shot_hit is honoured.
  - shot_done in any state other than FLY is ignored.
- RESOLVE (1 cycle):
  - On a hit, the shooter's score increments, saturating at 2^SCORE_W-1.
  - If the new score >= WIN_SCORE: game_over = 1, winner = cur_player, -> OVER.
  - Otherwise cur_player toggles and -> IDLE.
  - A miss or timeout toggles cur_player only.
- OVER: terminal; all requests ignored; left only by rst.
- Latency:
  - fire_req to cannon_turn high: 2 cycles.
  - shot_done to cur_player toggle (visible): 2 cycles.
- A fire_req held high across a turn change does not re-fire for the same player, because the player has toggled. The new player fires as soon as its own bit is high.

Test Plan:
- Reset, then fire_req=01 with angle_p0=0x2D, power_p0=0x40 -> cannon_turn high 2 cycles later. angle=0x2D, power=0x40, direction=1. Held until the first move_tick, low the cycle after.
- fire_req=10 while cur_player=0 for 100 cycles -> no cannon_turn, busy=0. Then fire_req=01 -> normal launch.
- Player 0 shot ends with shot_done+shot_hit=1 -> score_p0=1, cur_player=1 two cycles later. A following player 1 miss -> scores unchanged, cur_player=0.
- No shot_done for 1023 move_ticks -> RESOLVE as miss, cur_player toggles, no score change. shot_done on the 1023rd tick with hit=1 -> scored as a hit.
- Player 0 scores 5 hits interleaved with player 1 misses -> game_over=1, winner=0, state OVER. Further fire_req and shot_done are ignored; rst returns all outputs to 0.
- rst asserted during FLY -> next cycle: busy=0, cannon_turn=0, scores 0, cur_player 0. A late shot_done pulse is ignored.
